bnn_seq_loader: RTL and testbench
=================================

# bnn_seq_loader

Stream-side front end for the sequential BNN classifier core. Accepts one B-bit feature sample per valid/ready handshake, assembles a full N-sample frame into the core's parallel `data` word, and releases the core's reset for a fixed run window. It then captures the core's `klass` and presents it on a valid/ready result port. This block owns the core's reset, so one frame is classified per load/run cycle.

## Interface

Parameters:
- N, 128, samples per frame; must match core N
- B, 4, bits per sample
- M, 40, hidden neurons in the core; used only for the WAIT default
- C, 6, number of classes; result width is CL = $clog2(C)
- WAIT, 170, run-window length in clk cycles with core_rst low; default is N+M+2; must satisfy WAIT ≥ N+M+1

Ports:
- clk, in, 1, clock
- rst, in, 1, reset; asynchronous, active-high
- s_valid, in, 1, sample valid
- s_ready, out, 1, sample accept; a transfer occurs when s_valid && s_ready
- s_data, in, B, sample value, unsigned
- s_last, in, 1, marks the final sample of a frame
- core_rst, out, 1, registered reset driven to the BNN core
- core_data, out, N*B, frame word; sample k occupies [k*B +: B]
- core_klass, in, CL, class index from the core
- m_valid, out, 1, result valid
- m_ready, in, 1, result accept
- m_klass, out, CL, registered class result
- busy, out, 1, high in RUN and OUT
- err, out, 1, one-cycle pulse on a framing error

## Operation

States: LOAD, SYNC, RUN, OUT.

LOAD
- s_ready=1; core_rst=1.
- On each transfer, write s_data into core_data[idx*B +: B], then idx++.
- Transfer with idx<N-1 and s_last=1: framing error. Pulse err, set idx=0, stay in LOAD. The partial frame is discarded; stale core_data bits are not cleared.
- Transfer with idx=N-1 and s_last=1: set idx=0, go to RUN.
- Transfer with idx=N-1 and s_last=0: pulse err, set idx=0, go to SYNC.

SYNC
- s_ready=1; incoming samples are dropped and core_data is not written.
- A transfer with s_last=1 returns to LOAD.

RUN
- s_ready=0; core_rst=0; core_data is held stable.
- wcnt counts 0..WAIT-1.
- At wcnt=WAIT-1: m_klass<=core_klass, m_valid<=1, go to OUT, core_rst<=1.

OUT
- s_ready=0; core_rst=1; m_valid=1. m_klass holds until accepted.
- m_valid && m_ready: m_valid<=0, go to LOAD.

Widths and counters:
- idx is $clog2(N) bits.
- wcnt is $clog2(WAIT) bits and is cleared on entry to RUN.

## Timing

Reset values:
- state=LOAD, s_ready=1, core_rst=1, core_data=0
- m_valid=0, m_klass=0, err=0, busy=0, idx=0, wcnt=0

Core reset and run window:
- All outputs are registered. s_ready, busy, and core_rst are decoded from registered state.
- core_rst falls on the clk edge that accepts the final sample. It stays low for exactly WAIT cycles.
- core_rst rises on the same edge that sets m_valid.

Latency:
- From the final-sample transfer edge to m_valid=1 is WAIT cycles.
- From the m_ready handshake edge to s_ready=1 is 0 cycles; s_ready is high in the cycle after the handshake.
- Maximum throughput is one frame per N+WAIT+1 cycles when m_ready is held high.

Handshake rules:
- s_valid is ignored while s_ready=0.
- m_ready is ignored while m_valid=0.
- m_klass is stable while m_valid=1 and m_ready=0.

err:
- err is high for exactly the cycle after the offending transfer.
- Back-to-back errors produce back-to-back pulses.

Reset mid-operation:
- Async rst in any state returns all registers to their reset values immediately.
- core_rst asserts asynchronously; a frame in flight is lost and no result is emitted.

## Test plan

- Single frame: N=128 samples with s_data=k mod 16 and s_last on k=127, m_ready=1.
  - core_data[k*4 +: 4] = k mod 16.
  - core_rst is low for exactly 170 cycles.
  - m_valid pulses 1 cycle with m_klass equal to core_klass sampled at wcnt=169.
- Backpressure: hold m_ready=0 for 20 cycles after m_valid rises.
  - m_klass and m_valid stay constant; s_ready=0 and core_rst=1 throughout.
  - After m_ready=1, s_ready=1 on the next cycle.
- Early s_last at sample index 50.
  - err pulses once; no RUN entry.
  - The next full 128-sample frame classifies normally.
- Missing s_last at index 127.
  - err pulses; the state moves to SYNC.
  - 5 further samples are dropped, ending with s_last=1.
  - The following frame is accepted from idx=0.
- s_valid toggling 1/0 every cycle during LOAD.
  - Exactly 128 transfers fill the frame; core_rst falls on the 128th transfer edge.
- Async rst asserted at wcnt=60 in RUN.
  - Immediately: core_rst=1, m_valid=0, s_ready=1, busy=0.
  - No result is emitted for that frame.

Source files
------------

// File: rtl/bnn_seq_loader.sv
// Stream front end for the sequential BNN core: assembles an N-sample frame, runs the
// core for a fixed window with its reset released, then presents the class result.
//
// state | meaning
// LOAD  | accepting samples into core_data, core held in reset
// SYNC  | after a missing s_last: dropping samples until the next s_last
// RUN   | core out of reset, wcnt counts the run window
// OUT   | result presented on m_valid/m_klass, core held in reset
module bnn_seq_loader #(
    parameter int N    = 128,
    parameter int B    = 4,
    parameter int M    = 40,
    parameter int C    = 6,
    parameter int WAIT = N + M + 2,
    localparam int CL  = $clog2(C)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [B-1:0]    s_data,
    input  logic            s_last,
    output logic            core_rst,
    output logic [N*B-1:0]  core_data,
    input  logic [CL-1:0]   core_klass,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [CL-1:0]   m_klass,
    output logic            busy,
    output logic            err
);

    localparam int IW = $clog2(N);
    localparam int WW = $clog2(WAIT);
    localparam logic [IW-1:0] IDX_LAST  = IW'(N - 1);
    localparam logic [WW-1:0] WCNT_LAST = WW'(WAIT - 1);

    typedef enum logic [1:0] {LOAD, SYNC, RUN, OUT} state_t;

    state_t          state;
    logic [IW-1:0]   idx;
    logic [WW-1:0]   wcnt;

    // Decoded straight from the state register so an async reset reaches the core at once.
    assign s_ready  = (state == LOAD) || (state == SYNC);
    assign core_rst = (state != RUN);
    assign busy     = (state == RUN) || (state == OUT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= LOAD;
            idx       <= '0;
            wcnt      <= '0;
            core_data <= '0;
            m_valid   <= 1'b0;
            m_klass   <= '0;
            err       <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                LOAD: begin
                    if (s_valid) begin
                        core_data[idx*B +: B] <= s_data;
                        if (idx == IDX_LAST) begin
                            idx <= '0;
                            if (s_last) begin
                                state <= RUN;
                                wcnt  <= '0;
                            end else begin
                                err   <= 1'b1;
                                state <= SYNC;
                            end
                        end else if (s_last) begin
                            // Short frame: discard it and restart; stale bits are overwritten later.
                            err <= 1'b1;
                            idx <= '0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                SYNC: begin
                    if (s_valid && s_last) state <= LOAD;
                end
                RUN: begin
                    if (wcnt == WCNT_LAST) begin
                        m_klass <= core_klass;
                        m_valid <= 1'b1;
                        state   <= OUT;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                OUT: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        state   <= LOAD;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_bnn_seq_loader.sv
// Directed bench for bnn_seq_loader: framing, run window, result handshake, async reset.
module tb_bnn_seq_loader;

    localparam int N    = 128;
    localparam int B    = 4;
    localparam int WAIT = 170;
    localparam int CL   = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            s_valid = 1'b0;
    logic            s_ready;
    logic [B-1:0]    s_data = '0;
    logic            s_last = 1'b0;
    logic            core_rst;
    logic [N*B-1:0]  core_data;
    logic [CL-1:0]   core_klass = '0;
    logic            m_valid;
    logic            m_ready = 1'b1;
    logic [CL-1:0]   m_klass;
    logic            busy;
    logic            err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    bnn_seq_loader dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .core_rst(core_rst), .core_data(core_data), .core_klass(core_klass),
        .m_valid(m_valid), .m_ready(m_ready), .m_klass(m_klass),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // core_klass after edge k is k mod 6, so the edge k+1 sees (k mod 6).
    always @(negedge clk) core_klass = CL'(cyc % 6);

    task automatic check(input string tag, input logic [N*B-1:0] obs, input logic [N*B-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [B-1:0] pdat(input int pat, input int k);
        case (pat)
            0:       return B'(k % 16);
            1:       return B'((3 * k) % 16);
            2:       return B'((k + 5) % 16);
            default: return B'(15 - (k % 16));
        endcase
    endfunction

    function automatic logic [N*B-1:0] fword(input int pat);
        logic [N*B-1:0] w;
        w = '0;
        for (int k = 0; k < N; k++) w[k*B +: B] = pdat(pat, k);
        return w;
    endfunction

    task automatic send(input logic [B-1:0] d, input bit last);
        s_valid = 1'b1; s_data = d; s_last = last;
        @(posedge clk); #1;
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic frame(input int pat, input bit toggle, output int t);
        for (int k = 0; k < N; k++) begin
            if (toggle && k > 0) begin
                @(posedge clk); #1;
            end
            if (toggle && k == N - 1) check("toggle_rst_before_last", core_rst, 1);
            send(pdat(pat, k), k == N - 1);
        end
        t = cyc;
    endtask

    task automatic wait_result(input int t, input string tag);
        int n;
        int low;
        n = 0; low = 0;
        check({tag, "_rst_fall"}, core_rst, 0);
        check({tag, "_busy_run"}, busy, 1);
        check({tag, "_sready_run"}, s_ready, 0);
        while (n < WAIT + 10 && !m_valid) begin
            @(posedge clk); #1;
            n++;
            if (!m_valid && !core_rst) low++;
        end
        check({tag, "_latency"}, n, WAIT);
        check({tag, "_rst_low_cycles"}, low, WAIT - 1);
        check({tag, "_klass"}, m_klass, (t + WAIT - 1) % 6);
        check({tag, "_rst_rise"}, core_rst, 1);
    endtask

    task automatic take_result(input string tag);
        @(posedge clk); #1;
        check({tag, "_mvalid_drop"}, m_valid, 0);
        check({tag, "_sready_back"}, s_ready, 1);
        check({tag, "_busy_drop"}, busy, 0);
    endtask

    initial begin
        int t;
        int errs;
        int stable;
        logic [CL-1:0] held;

        // reset values
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_sready", s_ready, 1);
        check("rst_core_rst", core_rst, 1);
        check("rst_core_data", core_data, 0);
        check("rst_mvalid", m_valid, 0);
        check("rst_mklass", m_klass, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // single frame, m_ready held high
        m_ready = 1'b1;
        frame(0, 1'b0, t);
        check("f0_data", core_data, fword(0));
        wait_result(t, "f0");
        take_result("f0");

        // backpressure on the result port
        m_ready = 1'b0;
        frame(3, 1'b0, t);
        wait_result(t, "bp");
        held = m_klass;
        stable = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (m_valid && m_klass === held && !s_ready && core_rst && busy) stable++;
        end
        check("bp_stable_cycles", stable, 20);
        m_ready = 1'b1;
        take_result("bp");

        // early s_last at index 50
        errs = 0;
        for (int k = 0; k < 50; k++) begin
            send(pdat(1, k), 1'b0);
            if (err) errs++;
        end
        send(pdat(1, 50), 1'b1);
        check("early_err_pulse", err, 1);
        check("early_stay_load", core_rst, 1);
        check("early_sready", s_ready, 1);
        @(posedge clk); #1;
        check("early_err_once", err, 0);
        check("early_no_prior_err", errs, 0);
        // back-to-back short frames give back-to-back err pulses
        send(4'h9, 1'b1);
        check("b2b_err_first", err, 1);
        send(4'h6, 1'b1);
        check("b2b_err_second", err, 1);
        check("b2b_stay_load", core_rst, 1);
        frame(1, 1'b0, t);
        check("early_next_data", core_data, fword(1));
        wait_result(t, "early_next");
        take_result("early_next");

        // missing s_last at index 127
        for (int k = 0; k < N; k++) send(pdat(2, k), 1'b0);
        check("miss_err", err, 1);
        check("miss_sync_sready", s_ready, 1);
        check("miss_no_run", core_rst, 1);
        for (int k = 0; k < 5; k++) send(4'hF, k == 4);
        check("sync_dropped", core_data, fword(2));
        check("sync_no_run", core_rst, 1);
        check("sync_no_err", err, 0);
        frame(3, 1'b0, t);
        check("after_sync_data", core_data, fword(3));
        wait_result(t, "after_sync");
        take_result("after_sync");

        // s_valid toggling during LOAD
        frame(0, 1'b1, t);
        check("toggle_data", core_data, fword(0));
        wait_result(t, "toggle");
        take_result("toggle");

        // async reset in RUN at wcnt=60
        frame(1, 1'b0, t);
        repeat (60) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_core_rst", core_rst, 1);
        check("arst_mvalid", m_valid, 0);
        check("arst_sready", s_ready, 1);
        check("arst_busy", busy, 0);
        check("arst_core_data", core_data, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        stable = 0;
        for (int i = 0; i < WAIT + 20; i++) begin
            @(posedge clk); #1;
            if (m_valid || !core_rst) stable++;
        end
        check("arst_no_result", stable, 0);
        check("arst_idle_load", s_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
